sio_responder: RTL and testbench
================================

SIO_RESPONDER -- requirements
Module: sio_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, giving clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter TURN_BITS, default 2, giving bit periods of bus turnaround between the end of the receive stop bit and the transmit start bit.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sio  inout  1  open-drain half-duplex serial line; externally pulled up (tri1/pullup), idle = 1.
REQ-006 SHALL have port tx_data  input  8  reply byte from the core.
REQ-007 SHALL have port rx_data  output  8  last correctly received byte.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 SHALL have port rx_err  output  1  one-cycle pulse on a framing error.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at the end of the reply stop bit.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL drive sio only to 0 or z (never 1): sio = drv_low ? 0 : z.
REQ-013 SHALL pass sio through a 2-flop synchronizer (both flops reset to 1); all receive decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP.
REQ-015 IDLE: a synchronized 1->0 transition SHALL move to RX_START and clear the bit counter.
REQ-016 RX_START: after CLKS_PER_BIT/2 cycles, if the line is 0, SHALL go to RX_DATA; if it is 1 (glitch), SHALL return to IDLE with no output pulse.
REQ-017 RX_DATA: SHALL sample every CLKS_PER_BIT cycles (mid-bit), 8 bits, LSB first, into a shift register.
REQ-018 RX_STOP: at the mid-bit sample, line 1 SHALL load rx_data, pulse rx_valid the next cycle, latch tx_data in that same cycle, and go to TURN.
REQ-019 RX_STOP: line 0 SHALL pulse rx_err, leave rx_data unchanged, send no reply, and go to IDLE.
REQ-020 TURN: SHALL hold sio released for TURN_BITS*CLKS_PER_BIT cycles counted from the rx_valid cycle, then enter TX_START.
REQ-021 TX_START: SHALL drive sio 0 for CLKS_PER_BIT cycles.
REQ-022 TX_DATA: SHALL send the latched byte LSB first, each bit held CLKS_PER_BIT cycles (bit 0 -> drive 0, bit 1 -> release).
REQ-023 TX_STOP: SHALL release sio for CLKS_PER_BIT cycles, then pulse tx_done and return to IDLE in the same cycle.
REQ-024 SHALL ignore sio input transitions in TURN, TX_START, TX_DATA and TX_STOP; no receive starts until IDLE is re-entered.
REQ-025 tx_data changes after the latch cycle SHALL NOT affect the byte in flight.
REQ-026 rx_valid, rx_err and tx_done SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per event.
REQ-027 SHALL use a bit-period counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index that wraps 7->0 only on state exit.

Reset
REQ-028 On rst=1, SHALL immediately, without waiting for a clock edge, release sio (z) and enter IDLE.
REQ-029 On rst=1, SHALL clear rx_data to 8'h00, clear rx_valid, rx_err, tx_done and busy to 0, clear all counters to 0, and set the synchronizer flops to 1.
REQ-030 Reset asserted mid-receive or mid-transmit SHALL abort the frame with no pulses; after release, the next falling edge starts a fresh receive.

Verification (CLKS_PER_BIT=8, TURN_BITS=2, sio with pullup)
REQ-031 Reset: rst=1 for 3 cycles -> sio=1, busy=0, rx_data=8'h00, no pulses.
REQ-032 Receive then reply: send 0x3C with tx_data=0xC3 -> rx_valid pulse with rx_data=8'h3C; sio falls 16 cycles after rx_valid; reply bits 1,1,0,0,0,0,1,1 at 8-cycle spacing; tx_done pulses after the stop bit; busy=0.
REQ-033 Glitch: sio low for 2 cycles only -> no rx_valid and no rx_err, busy returns to 0, sio is never driven.
REQ-034 Framing error: send 0x55 with a 0 stop bit -> rx_err pulse, rx_data keeps its prior value, sio stays 1 for 40 following cycles.
REQ-035 Reset mid-reply: assert rst during TX_DATA while sio=0 -> sio=1 before the next clk edge; no tx_done.
REQ-036 Data stability: change tx_data to 0xFF during TURN -> transmitted byte is still the value latched at rx_valid.

Source files
------------

// File: rtl/sio_responder.sv
// rtl/sio_responder.sv - half-duplex open-drain serial responder: receive one byte, turn the bus around, reply with one byte
//
// Purpose:
//   Listens on a single open-drain line for a UART-style frame (start 0, 8 data
//   bits LSB first, stop 1). On a good frame it publishes the byte, latches the
//   core's reply byte, waits a turnaround gap and then sends the reply on the
//   same line. A bad stop bit is reported and nothing is sent back.
//
// Ports:
//   clk       in     single clock, rising edge
//   rst       in     asynchronous active-high reset
//   sio       inout  open-drain line; only ever pulled to 0 or released
//   tx_data   in     [7:0] reply byte, latched when a frame is accepted
//   rx_data   out    [7:0] last correctly received byte
//   rx_valid  out    one-cycle pulse when rx_data updates
//   rx_err    out    one-cycle pulse on a framing error
//   tx_done   out    one-cycle pulse at the end of the reply stop bit
//   busy      out    high in every state except IDLE

module sio_responder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int TURN_BITS    = 2
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        sio,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       tx_done,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TW = (TURN_BITS > 1) ? $clog2(TURN_BITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX_START = 3'd1,
      ST_RX_DATA  = 3'd2,
      ST_RX_STOP  = 3'd3,
      ST_TURN     = 3'd4,
      ST_TX_START = 3'd5,
      ST_TX_DATA  = 3'd6,
      ST_TX_STOP  = 3'd7
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [TW-1:0] r_turn;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_sync_last;
   logic [7:0]    r_rx_shift;
   logic [7:0]    r_rx_data;
   logic [7:0]    r_tx_byte;
   logic          r_drv_low;
   logic          r_rx_valid;
   logic          r_rx_err;
   logic          r_tx_done;

   logic          w_fall;
   logic          w_bit_end;
   logic [2:0]    w_bit_next;

   // Gating with rst makes the line release immediately, independent of the
   // flop's asynchronous clear settling.
   assign sio = (r_drv_low && !rst) ? 1'b0 : 1'bz;

   assign w_fall     = r_sync_last & ~r_sync2;
   assign w_bit_end  = (r_cnt == CNT_LAST);
   assign w_bit_next = r_bit + 3'd1;

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign rx_err   = r_rx_err;
   assign tx_done  = r_tx_done;
   assign busy     = (r_state != ST_IDLE);

   // Line synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_last <= 1'b1;
      end else begin
         r_sync1     <= sio;
         r_sync2     <= r_sync1;
         r_sync_last <= r_sync2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_bit      <= 3'd0;
         r_turn     <= '0;
         r_rx_shift <= 8'h00;
         r_rx_data  <= 8'h00;
         r_tx_byte  <= 8'h00;
         r_drv_low  <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         r_tx_done  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         r_tx_done  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_drv_low <= 1'b0;
               if (w_fall) begin
                  r_state <= ST_RX_START;
                  r_cnt   <= '0;
                  r_bit   <= 3'd0;
               end
            end

            // Wait half a bit so that all later samples land mid-bit.
            ST_RX_START: begin
               if (r_cnt == HALF_LAST) begin
                  r_cnt <= '0;
                  if (!r_sync2) begin
                     r_state <= ST_RX_DATA;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_RX_DATA: begin
               if (w_bit_end) begin
                  r_cnt      <= '0;
                  r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                  r_bit      <= w_bit_next;
                  if (r_bit == 3'd7) begin
                     r_state <= ST_RX_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // A good stop bit publishes the byte and captures the reply in the
            // same edge, so the first TURN cycle is the rx_valid cycle.
            ST_RX_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_sync2) begin
                     r_rx_data  <= r_rx_shift;
                     r_rx_valid <= 1'b1;
                     r_tx_byte  <= tx_data;
                     r_turn     <= '0;
                     r_state    <= ST_TURN;
                  end else begin
                     r_rx_err <= 1'b1;
                     r_state  <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_TURN: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_turn == TURN_LAST) begin
                     r_turn    <= '0;
                     r_state   <= ST_TX_START;
                     r_drv_low <= 1'b1;
                  end else begin
                     r_turn <= r_turn + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_TX_START: begin
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_bit     <= 3'd0;
                  r_drv_low <= ~r_tx_byte[0];
                  r_state   <= ST_TX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // The drive level for the next bit is set on the edge that ends the
            // current one, keeping every bit exactly CLKS_PER_BIT cycles long.
            ST_TX_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  r_bit <= w_bit_next;
                  if (r_bit == 3'd7) begin
                     r_drv_low <= 1'b0;
                     r_state   <= ST_TX_STOP;
                  end else begin
                     r_drv_low <= ~r_tx_byte[w_bit_next];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_TX_STOP: begin
               r_drv_low <= 1'b0;
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_tx_done <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_drv_low <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sio_responder.sv
// tb/tb_sio_responder.sv - directed self-checking bench for sio_responder

module tb_sio_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tb_drv = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       tx_done;
   logic       busy;
   wire        sio;

   pullup (sio);
   assign sio = tb_drv ? 1'b0 : 1'bz;

   sio_responder #(.CLKS_PER_BIT(8), .TURN_BITS(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sio      (sio),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .tx_done  (tx_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int n_done = 0;
   int n_overlap = 0;
   int valid_cyc = 0;
   int done_cyc = 0;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (rx_valid) begin
         n_valid = n_valid + 1;
         valid_cyc = cyc;
      end
      if (rx_err) n_err = n_err + 1;
      if (tx_done) begin
         n_done = n_done + 1;
         done_cyc = cyc;
      end
      if (int'(rx_valid) + int'(rx_err) + int'(tx_done) > 1) n_overlap = n_overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      tb_drv = 1'b1;
      repeat (8) tick();
      for (int i = 0; i < 8; i++) begin
         tb_drv = ~b[i];
         repeat (8) tick();
      end
      tb_drv = ~stop_bit;
      repeat (8) tick();
      tb_drv = 1'b0;
   endtask

   task automatic wait_fall(input string tag, output int fall_cyc);
      bit found;
      found = 1'b0;
      fall_cyc = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (sio === 1'b0) begin
            found = 1'b1;
            fall_cyc = cyc;
         end
      end
      check({tag, "_start_seen"}, 32'(found), 32'd1);
   endtask

   task automatic run_exchange(input string tag, input logic [7:0] rxb,
                               input logic [7:0] txb, input bit change_tx);
      int v0;
      int d0;
      int fall_cyc;
      bit found;
      v0 = n_valid;
      d0 = n_done;
      tx_data = txb;
      send_byte(rxb, 1'b1);
      check({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'd1);
      check({tag, "_rx_data"}, 32'(rx_data), 32'(rxb));
      if (change_tx) tx_data = 8'hFF;
      wait_fall(tag, fall_cyc);
      check({tag, "_turn_gap"}, 32'(fall_cyc - valid_cyc), 32'd16);
      repeat (4) tick();
      check({tag, "_start_bit"}, 32'(sio), 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (8) tick();
         check($sformatf("%s_bit%0d", tag, i), 32'(sio), 32'(txb[i]));
      end
      repeat (8) tick();
      check({tag, "_stop_bit"}, 32'(sio), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (n_done != d0) found = 1'b1;
      end
      check({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
      check({tag, "_done_time"}, 32'(done_cyc - fall_cyc), 32'd80);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int v0;
      int d0;
      int bad;
      int fall_cyc;

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      check("rst_sio", 32'(sio), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_pulses", 32'(n_valid + n_err + n_done), 32'd0);
      rst = 1'b0;
      repeat (4) tick();

      // Receive then reply
      run_exchange("xch1", 8'h3C, 8'hC3, 1'b0);
      repeat (5) tick();

      // Glitch
      v0 = n_valid;
      e0 = n_err;
      tb_drv = 1'b1;
      repeat (2) tick();
      tb_drv = 1'b0;
      repeat (2) tick();
      check("glitch_busy_high", 32'(busy), 32'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sio !== 1'b1) bad = bad + 1;
      end
      check("glitch_sio_released", 32'(bad), 32'd0);
      check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
      check("glitch_no_err", 32'(n_err - e0), 32'd0);
      check("glitch_busy_end", 32'(busy), 32'd0);

      // Framing error
      v0 = n_valid;
      e0 = n_err;
      d0 = n_done;
      tx_data = 8'h00;
      send_byte(8'h55, 1'b0);
      check("frm_err_cnt", 32'(n_err - e0), 32'd1);
      check("frm_rx_data_kept", 32'(rx_data), 32'h3C);
      check("frm_no_valid", 32'(n_valid - v0), 32'd0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (sio !== 1'b1) bad = bad + 1;
      end
      check("frm_no_reply", 32'(bad), 32'd0);
      check("frm_no_done", 32'(n_done - d0), 32'd0);
      check("frm_busy_end", 32'(busy), 32'd0);

      // Data stability: tx_data changes during TURN
      run_exchange("stab", 8'hA5, 8'h5A, 1'b1);
      repeat (5) tick();

      // Reset in the middle of the reply while the line is driven low
      d0 = n_done;
      v0 = n_valid;
      tx_data = 8'h00;
      send_byte(8'h00, 1'b1);
      check("mrst_valid_cnt", 32'(n_valid - v0), 32'd1);
      wait_fall("mrst", fall_cyc);
      repeat (12) tick();
      check("mrst_sio_low", 32'(sio), 32'd0);
      rst = 1'b1;
      #1;
      check("mrst_sio_async", 32'(sio), 32'd1);
      check("mrst_busy_async", 32'(busy), 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (sio !== 1'b1) bad = bad + 1;
      end
      check("mrst_line_idle", 32'(bad), 32'd0);
      check("mrst_no_done", 32'(n_done - d0), 32'd0);
      check("mrst_rx_data_clr", 32'(rx_data), 32'h00);
      check("mrst_busy", 32'(busy), 32'd0);

      // Fresh exchange after reset
      run_exchange("post", 8'h81, 8'h7E, 1'b0);
      repeat (5) tick();

      check("pulse_overlap", 32'(n_overlap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
